// File: rtl/fip_32_div_seq.sv
// ----------------------------------------------------------------------------
// fip_32_div_seq
// Sequential signed fixed-point divider, Q(32-FRA_BITS).FRA_BITS format.
// One radix-2 restoring step per clock. Valid/ready handshake on both sides.
// The quotient is truncated toward zero.
//
// Parameters:
//   FRA_BITS  fractional bits of operands and result (must be >= 1)
//   SAT       1: saturate on overflow; 0: wrap to the low 32 bits
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst    asynchronous active-high reset
//   i_valid  operand pair valid
//   o_ready  divider idle and able to accept operands
//   i_x      signed dividend
//   i_y      signed divisor
//   o_valid  result valid (held until i_ready)
//   i_ready  consumer accepts the result
//   o_z      signed quotient
//   o_div0   result came from a zero divisor
//   o_ovf    quotient exceeded the 32-bit range
// ----------------------------------------------------------------------------
module fip_32_div_seq #(
    parameter int FRA_BITS = 16,
    parameter bit SAT      = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_x,
    input  logic [31:0] i_y,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_z,
    output logic        o_div0,
    output logic        o_ovf
);

    localparam int N  = 32 + FRA_BITS;
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic            sign;       // result sign, or the dividend sign on divide-by-zero
    logic            div0_pend;  // zero divisor: CALC lasts one cycle and skips the quotient
    logic [31:0]     ay;         // |y|
    logic [N-1:0]    d;          // shifted dividend |x| << FRA_BITS
    logic [31:0]     r;          // partial remainder, always < |y| <= 2^31
    logic [N-1:0]    q;          // quotient magnitude being assembled
    logic [CW-1:0]   cnt;

    // Operand magnitudes; |0x80000000| = 2^31 fits in 32 unsigned bits.
    logic [31:0] ax_c, ay_c;
    assign ax_c = i_x[31] ? (~i_x + 32'd1) : i_x;
    assign ay_c = i_y[31] ? (~i_y + 32'd1) : i_y;

    // One restoring step.
    logic [32:0]  r_sh, r_sub;
    logic         ge;
    logic [31:0]  r_nxt;
    logic [N-1:0] q_nxt;

    assign r_sh  = {r, d[N-1]};
    assign ge    = (r_sh >= {1'b0, ay});
    assign r_sub = r_sh - {1'b0, ay};
    assign r_nxt = ge ? r_sub[31:0] : r_sh[31:0];
    assign q_nxt = {q[N-2:0], ge};

    // Result formation from the final quotient magnitude.
    logic        ovf_c;
    logic [31:0] neg_c, wrap_c, sat_c, z_c;

    // A negative result may reach exactly 2^31; a positive one only 2^31-1.
    assign ovf_c  = sign ? ((|q_nxt[N-1:32]) | (q_nxt[31] & (|q_nxt[30:0])))
                         : (|q_nxt[N-1:31]);
    assign neg_c  = ~q_nxt[31:0] + 32'd1;
    assign wrap_c = sign ? neg_c : q_nxt[31:0];
    assign sat_c  = sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
    assign z_c    = (ovf_c && SAT) ? sat_c : wrap_c;

    assign o_ready = (state == IDLE) & ~i_rst;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            sign      <= 1'b0;
            div0_pend <= 1'b0;
            ay        <= '0;
            d         <= '0;
            r         <= '0;
            q         <= '0;
            cnt       <= '0;
            o_valid   <= 1'b0;
            o_z       <= '0;
            o_div0    <= 1'b0;
            o_ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        state <= CALC;
                        r     <= '0;
                        q     <= '0;
                        ay    <= ay_c;
                        d     <= {ax_c, {FRA_BITS{1'b0}}};
                        if (i_y == 32'd0) begin
                            // Single pass through CALC gives the one-cycle latency.
                            div0_pend <= 1'b1;
                            sign      <= i_x[31];
                            cnt       <= '0;
                        end else begin
                            div0_pend <= 1'b0;
                            sign      <= i_x[31] ^ i_y[31];
                            cnt       <= CW'(N - 1);
                        end
                    end
                end

                CALC: begin
                    r <= r_nxt;
                    q <= q_nxt;
                    d <= d << 1;
                    if (cnt == '0) begin
                        state   <= DONE;
                        o_valid <= 1'b1;
                        if (div0_pend) begin
                            o_z    <= sat_c;
                            o_div0 <= 1'b1;
                            o_ovf  <= 1'b0;
                        end else begin
                            o_z    <= z_c;
                            o_div0 <= 1'b0;
                            o_ovf  <= ovf_c;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end

                DONE: begin
                    if (i_ready) begin
                        state   <= IDLE;
                        o_valid <= 1'b0;
                        o_z     <= '0;
                        o_div0  <= 1'b0;
                        o_ovf   <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fip_32_div_seq.sv
// ----------------------------------------------------------------------------
// tb_fip_32_div_seq
// Directed bench for fip_32_div_seq. Two instances share the inputs: one with
// saturation, one with wrap, so overflow vectors check both behaviours.
// ----------------------------------------------------------------------------
module tb_fip_32_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_ready;
    logic [31:0] i_x, i_y;

    logic        rdy_s, vld_s, d0_s, ov_s;
    logic [31:0] z_s;
    logic        rdy_w, vld_w, d0_w, ov_w;
    logic [31:0] z_w;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fip_32_div_seq #(.FRA_BITS(16), .SAT(1'b1)) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(rdy_s),
        .i_x(i_x), .i_y(i_y), .o_valid(vld_s), .i_ready(i_ready),
        .o_z(z_s), .o_div0(d0_s), .o_ovf(ov_s)
    );

    fip_32_div_seq #(.FRA_BITS(16), .SAT(1'b0)) dut_wrap (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(rdy_w),
        .i_x(i_x), .i_y(i_y), .o_valid(vld_w), .i_ready(i_ready),
        .o_z(z_w), .o_div0(d0_w), .o_ovf(ov_w)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Count edges from acceptance until o_valid, bounded.
    task automatic wait_valid(output int lat, output logic rdy_seen);
        lat      = 0;
        rdy_seen = 1'b0;
        while (!vld_s && lat < 200) begin
            if (rdy_s) rdy_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Present operands at a negedge; return after the acceptance edge.
    task automatic launch(input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        i_x     = x;
        i_y     = y;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic take(input string tag);
        @(negedge clk);
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        chk({tag, ".vld_low"}, {31'd0, vld_s}, 32'd0);
    endtask

    typedef struct {
        logic [31:0] x, y, z, zw;
        logic        d0, ovs, ovw;
        int          lat;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int          lat;
        logic        rdy_seen;
        logic [31:0] hold_z;
        string       t;

        tbl[0]  = '{32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 32'h0001_8000, 1'b0, 1'b0, 1'b0, 48};
        tbl[1]  = '{32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 32'hFFFF_AAAB, 1'b0, 1'b0, 1'b0, 48};
        tbl[2]  = '{32'h0001_0000, 32'hFFFD_0000, 32'hFFFF_AAAB, 32'hFFFF_AAAB, 1'b0, 1'b0, 1'b0, 48};
        tbl[3]  = '{32'hFFFF_0000, 32'hFFFD_0000, 32'h0000_5555, 32'h0000_5555, 1'b0, 1'b0, 1'b0, 48};
        tbl[4]  = '{32'h7FFF_0000, 32'h0000_8000, 32'h7FFF_FFFF, 32'hFFFE_0000, 1'b0, 1'b1, 1'b1, 48};
        tbl[5]  = '{32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 48};
        tbl[6]  = '{32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 48};
        tbl[7]  = '{32'h0005_0000, 32'h0000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1};
        tbl[8]  = '{32'hFFFB_0000, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1};
        tbl[9]  = '{32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1};
        tbl[10] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 48};

        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_x = '0; i_y = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.vld",  {31'd0, vld_s}, 32'd0);
        chk("rst.z",    z_s, 32'd0);
        chk("rst.flag", {30'd0, d0_s, ov_s}, 32'd0);
        chk("rst.rdy",  {31'd0, rdy_s}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst.rdy", {31'd0, rdy_s}, 32'd1);

        // Directed vectors
        for (int i = 0; i < 11; i++) begin
            t = $sformatf("v%0d", i);
            launch(tbl[i].x, tbl[i].y);
            wait_valid(lat, rdy_seen);
            chk({t, ".lat"},   lat, tbl[i].lat);
            chk({t, ".rdy"},   {31'd0, rdy_seen}, 32'd0);
            chk({t, ".z"},     z_s, tbl[i].z);
            chk({t, ".div0"},  {31'd0, d0_s}, {31'd0, tbl[i].d0});
            chk({t, ".ovf"},   {31'd0, ov_s}, {31'd0, tbl[i].ovs});
            chk({t, ".zw"},    z_w, tbl[i].zw);
            chk({t, ".ovfw"},  {31'd0, ov_w}, {31'd0, tbl[i].ovw});
            chk({t, ".div0w"}, {31'd0, d0_w}, {31'd0, tbl[i].d0});
            take(t);
        end

        // Backpressure: hold the result while new operands are offered.
        launch(32'h0003_0000, 32'h0002_0000);
        wait_valid(lat, rdy_seen);
        chk("bp.lat", lat, 48);
        hold_z = z_s;
        @(negedge clk);
        i_x = 32'h0001_0000; i_y = 32'h0004_0000; i_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp.vld", {31'd0, vld_s}, 32'd1);
            chk("bp.z",   z_s, 32'h0001_8000);
            chk("bp.rdy", {31'd0, rdy_s}, 32'd0);
        end
        chk("bp.hold", z_s, hold_z);
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        chk("bp.xfer", {31'd0, vld_s}, 32'd0);
        chk("bp.rdy_after", {31'd0, rdy_s}, 32'd1);
        @(posedge clk); #1;          // next operands accepted here
        i_valid = 1'b0;
        chk("bp.accept", {31'd0, rdy_s}, 32'd0);
        wait_valid(lat, rdy_seen);
        chk("bp2.lat", lat, 48);
        chk("bp2.z",   z_s, 32'h0000_4000);
        take("bp2");

        // Asynchronous reset mid-CALC
        launch(32'h0003_0000, 32'h0002_0000);
        repeat (20) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst.vld", {31'd0, vld_s}, 32'd0);
        chk("arst.z",   z_s, 32'd0);
        chk("arst.rdy", {31'd0, rdy_s}, 32'd0);
        // Finishing the discarded op would need 28 more edges; none must appear.
        repeat (30) @(posedge clk);
        #1;
        chk("arst.hold", {31'd0, vld_s}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst.rel_rdy", {31'd0, rdy_s}, 32'd1);
        launch(32'h0003_0000, 32'h0002_0000);
        wait_valid(lat, rdy_seen);
        chk("arst2.lat", lat, 48);
        chk("arst2.z",   z_s, 32'h0001_8000);

        // Asynchronous reset while holding a result in DONE
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_done.vld", {31'd0, vld_s}, 32'd0);
        chk("arst_done.z",   z_s, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
